// File: rtl/usr_shift_controller.sv
// Command sequencer for a universal shift register. It accepts one command
// per handshake. For each command it loads a word into the register, applies
// N left or right shifts with a programmable serial fill bit, and collects
// the bits that leave the register. It then reports the final register word
// and the collected bits together with a one-cycle result strobe.
module usr_shift_controller #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    output logic [1:0]       sr_sel,
    output logic [WIDTH-1:0] sr_p_in,
    output logic             sr_s_right_in,
    output logic             sr_s_left_in,
    input  logic [WIDTH-1:0] sr_p_out,
    input  logic             sr_s_right_out,
    input  logic             sr_s_left_out,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_data,
    output logic [WIDTH-1:0] result_spill
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               dir_r;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH-1:0]   data_r;
    logic               fill_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   spill_r;
    logic [WIDTH-1:0]   hold_data_r;
    logic [WIDTH-1:0]   hold_spill_r;
    logic               exit_s;

    // Next-state logic: LOAD always lasts one cycle, and SHIFT ends on the
    // last remaining shift.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (count_r == {CNT_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Moore decode of the register controls from the state and the latched
    // command fields.
    always_comb begin
        sr_sel        = 2'b00;
        sr_p_in       = {WIDTH{1'b0}};
        sr_s_right_in = 1'b0;
        sr_s_left_in  = 1'b0;
        case (state_r)
            LOAD: begin
                sr_sel  = 2'b11;
                sr_p_in = data_r;
            end
            SHIFT: begin
                if (dir_r) begin
                    sr_sel       = 2'b10;
                    sr_s_left_in = fill_r;
                end else begin
                    sr_sel        = 2'b01;
                    sr_s_right_in = fill_r;
                end
            end
            default: begin
                sr_sel = 2'b00;
            end
        endcase
    end

    // Select the bit that leaves the register in the active shift direction.
    always_comb begin
        if (dir_r) begin
            exit_s = sr_s_left_out;
        end else begin
            exit_s = sr_s_right_out;
        end
    end

    // State, latched command, shift counter, spill collection and the
    // result holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            dir_r        <= 1'b0;
            count_r      <= {CNT_W{1'b0}};
            data_r       <= {WIDTH{1'b0}};
            fill_r       <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            spill_r      <= {WIDTH{1'b0}};
            hold_data_r  <= {WIDTH{1'b0}};
            hold_spill_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_r   <= cmd_dir;
                        count_r <= cmd_count;
                        data_r  <= cmd_data;
                        fill_r  <= cmd_fill;
                        spill_r <= {WIDTH{1'b0}};
                    end
                end
                LOAD: begin
                    cnt_r <= count_r;
                end
                SHIFT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (dir_r) begin
                        spill_r <= {spill_r[WIDTH-2:0], exit_s};
                    end else begin
                        spill_r <= {exit_s, spill_r[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    hold_data_r  <= sr_p_out;
                    hold_spill_r <= spill_r;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Handshake and result outputs. During DONE the outputs show the live
    // register word and the spill, and after DONE they show the held copies.
    always_comb begin
        cmd_ready    = (state_r == IDLE) && !rst;
        busy         = (state_r != IDLE);
        result_valid = (state_r == DONE);
        if (state_r == DONE) begin
            result_data  = sr_p_out;
            result_spill = spill_r;
        end else begin
            result_data  = hold_data_r;
            result_spill = hold_spill_r;
        end
    end

endmodule

// File: tb/tb_usr_shift_controller.sv
// Directed testbench for usr_shift_controller. The bench contains a
// behavioural universal shift register attached to the controller.
module tb_usr_shift_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [2:0] cmd_count;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic [1:0] sr_sel;
    logic [3:0] sr_p_in;
    logic       sr_s_right_in;
    logic       sr_s_left_in;
    logic [3:0] sr_p_out;
    logic       sr_s_right_out;
    logic       sr_s_left_out;
    logic       busy;
    logic       result_valid;
    logic [3:0] result_data;
    logic [3:0] result_spill;

    logic [3:0] sr_q = 4'b0000;
    int checks   = 0;
    int failures = 0;

    usr_shift_controller #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .sr_sel(sr_sel), .sr_p_in(sr_p_in),
        .sr_s_right_in(sr_s_right_in), .sr_s_left_in(sr_s_left_in),
        .sr_p_out(sr_p_out), .sr_s_right_out(sr_s_right_out),
        .sr_s_left_out(sr_s_left_out),
        .busy(busy), .result_valid(result_valid),
        .result_data(result_data), .result_spill(result_spill)
    );

    always #5 clk = ~clk;

    // Behavioural universal shift register.
    always @(posedge clk) begin
        case (sr_sel)
            2'b01:   sr_q <= {sr_s_right_in, sr_q[3:1]};
            2'b10:   sr_q <= {sr_q[2:0], sr_s_left_in};
            2'b11:   sr_q <= sr_p_in;
            default: sr_q <= sr_q;
        endcase
    end
    assign sr_p_out       = sr_q;
    assign sr_s_right_out = sr_q[0];
    assign sr_s_left_out  = sr_q[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command on the next edge. Returns at the negedge of the LOAD cycle.
    task automatic send(input logic dir, input logic [2:0] cnt, input logic [3:0] data, input logic fill);
        cmd_dir   = dir;
        cmd_count = cnt;
        cmd_data  = data;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
        cmd_count = 3'd0; cmd_data = 4'd0; cmd_fill = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sel",   32'(sr_sel), 32'h0);
        chk("rst_pin",   32'(sr_p_in), 32'h0);
        chk("rst_sri",   32'(sr_s_right_in), 32'h0);
        chk("rst_sli",   32'(sr_s_left_in), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_rv",    32'(result_valid), 32'h0);
        chk("rst_data",  32'(result_data), 32'h0);
        chk("rst_spill", 32'(result_spill), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_ready_rel", 32'(cmd_ready), 32'h1);

        // Load only, data 1001
        send(1'b0, 3'd0, 4'b1001, 1'b0);
        chk("t1_sel_load", 32'(sr_sel), 32'h3);
        chk("t1_pin",      32'(sr_p_in), 32'h9);
        chk("t1_busy",     32'(busy), 32'h1);
        chk("t1_ready",    32'(cmd_ready), 32'h0);
        chk("t1_rv_load",  32'(result_valid), 32'h0);
        @(negedge clk);
        chk("t1_rv",       32'(result_valid), 32'h1);
        chk("t1_sel_done", 32'(sr_sel), 32'h0);
        chk("t1_data",     32'(result_data), 32'h9);
        chk("t1_spill",    32'(result_spill), 32'h0);
        @(negedge clk);
        chk("t1_ready_back", 32'(cmd_ready), 32'h1);
        chk("t1_rv_low",     32'(result_valid), 32'h0);
        chk("t1_data_hold",  32'(result_data), 32'h9);

        // Right shift 1001, count 2, fill 1
        send(1'b0, 3'd2, 4'b1001, 1'b1);
        chk("t2_sel0", 32'(sr_sel), 32'h3);
        @(negedge clk);
        chk("t2_sel1", 32'(sr_sel), 32'h1);
        chk("t2_sri",  32'(sr_s_right_in), 32'h1);
        chk("t2_sli",  32'(sr_s_left_in), 32'h0);
        @(negedge clk);
        chk("t2_sel2", 32'(sr_sel), 32'h1);
        chk("t2_rv_early", 32'(result_valid), 32'h0);
        @(negedge clk);
        chk("t2_sel3",  32'(sr_sel), 32'h0);
        chk("t2_rv",    32'(result_valid), 32'h1);
        chk("t2_data",  32'(result_data), 32'hE);
        chk("t2_spill", 32'(result_spill), 32'h4);
        @(negedge clk);
        chk("t2_ready", 32'(cmd_ready), 32'h1);

        // Left shift 1001, count 3, fill 0
        send(1'b1, 3'd3, 4'b1001, 1'b0);
        chk("t3_sel_load", 32'(sr_sel), 32'h3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_sel_shift", 32'(sr_sel), 32'h2);
            chk("t3_sri",       32'(sr_s_right_in), 32'h0);
        end
        @(negedge clk);
        chk("t3_rv",    32'(result_valid), 32'h1);
        chk("t3_data",  32'(result_data), 32'h8);
        chk("t3_spill", 32'(result_spill), 32'h4);
        chk("t3_sri_done", 32'(sr_s_right_in), 32'h0);
        @(negedge clk);
        chk("t3_ready", 32'(cmd_ready), 32'h1);

        // Overlong right shift 1111, count 7, fill 0
        send(1'b0, 3'd7, 4'b1111, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t4_rv_early", 32'(result_valid), 32'h0);
        end
        @(negedge clk);
        chk("t4_rv",    32'(result_valid), 32'h1);
        chk("t4_data",  32'(result_data), 32'h0);
        chk("t4_spill", 32'(result_spill), 32'h1);
        @(negedge clk);
        chk("t4_ready", 32'(cmd_ready), 32'h1);

        // cmd_valid held high, fields changing while busy
        cmd_dir = 1'b0; cmd_count = 3'd1; cmd_data = 4'b0011; cmd_fill = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("t5_ready_load", 32'(cmd_ready), 32'h0);
        chk("t5_pin_a",      32'(sr_p_in), 32'h3);
        cmd_dir = 1'b1; cmd_count = 3'd7; cmd_data = 4'b1111; cmd_fill = 1'b1;
        @(negedge clk);
        chk("t5_sel_a", 32'(sr_sel), 32'h1);
        chk("t5_sri_a", 32'(sr_s_right_in), 32'h0);
        cmd_dir = 1'b0; cmd_count = 3'd2; cmd_data = 4'b0110; cmd_fill = 1'b1;
        @(negedge clk);
        chk("t5_rv_a",    32'(result_valid), 32'h1);
        chk("t5_data_a",  32'(result_data), 32'h1);
        chk("t5_spill_a", 32'(result_spill), 32'h8);
        chk("t5_ready_done", 32'(cmd_ready), 32'h0);
        cmd_dir = 1'b1; cmd_count = 3'd1; cmd_data = 4'b1101; cmd_fill = 1'b1;
        @(negedge clk);
        chk("t5_ready_idle", 32'(cmd_ready), 32'h1);
        chk("t5_busy_idle",  32'(busy), 32'h0);
        @(negedge clk);
        chk("t5_sel_b_load", 32'(sr_sel), 32'h3);
        chk("t5_pin_b",      32'(sr_p_in), 32'hD);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_sel_b", 32'(sr_sel), 32'h2);
        chk("t5_sli_b", 32'(sr_s_left_in), 32'h1);
        chk("t5_sri_b", 32'(sr_s_right_in), 32'h0);
        @(negedge clk);
        chk("t5_rv_b",    32'(result_valid), 32'h1);
        chk("t5_data_b",  32'(result_data), 32'hB);
        chk("t5_spill_b", 32'(result_spill), 32'h1);
        @(negedge clk);
        chk("t5_ready_end", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        chk("t5_no_extra", 32'(busy), 32'h0);
        chk("t5_rv_quiet", 32'(result_valid), 32'h0);

        // Reset during the second SHIFT cycle
        send(1'b0, 3'd3, 4'b1010, 1'b1);
        @(negedge clk);
        chk("t6_sel_s1", 32'(sr_sel), 32'h1);
        @(negedge clk);
        chk("t6_sel_s2", 32'(sr_sel), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_sel",   32'(sr_sel), 32'h0);
        chk("t6_busy",  32'(busy), 32'h0);
        chk("t6_rv",    32'(result_valid), 32'h0);
        chk("t6_ready_in_rst", 32'(cmd_ready), 32'h0);
        chk("t6_data",  32'(result_data), 32'h0);
        chk("t6_spill", 32'(result_spill), 32'h0);
        rst = 1'b0;
        #1;
        chk("t6_ready", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_rv",  32'(result_valid), 32'h0);
            chk("t6_idle",   32'(busy), 32'h0);
        end

        // Recovery after abort: load only 0110
        send(1'b1, 3'd0, 4'b0110, 1'b0);
        @(negedge clk);
        chk("t7_rv",    32'(result_valid), 32'h1);
        chk("t7_data",  32'(result_data), 32'h6);
        chk("t7_spill", 32'(result_spill), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
